// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit add/subtract: STAGES carry-chain segments, latency STAGES, one beat per cycle.
// Backpressure: one global advance (adv = !out_valid || out_ready) freezes every stage, so outputs hold while stalled.
module pipelined_adder_sub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Each stage carries the full operand/result words; only the slices it
    // still needs (operands) or has produced (results) are meaningful.
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];

    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_d [STAGES];

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    assign out_valid = v_q[LAST];
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;

    // Subtraction becomes a + ~b + ~cin, folded in before the first slice.
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;

    always_comb begin
        logic [SW:0] t;
        t      = {1'b0, a[SW-1:0]} + {1'b0, b_eff[SW-1:0]} + {{SW{1'b0}}, cin_eff};
        a_d[0] = a;
        b_d[0] = b_eff;
        s_d[0] = '0;
        s_d[0][SW-1:0] = t[SW-1:0];
        c_d[0] = t[SW];
        for (int k = 1; k < STAGES; k++) begin
            t      = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
                   + {{SW{1'b0}}, c_q[k-1]};
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            s_d[k][k*SW +: SW] = t[SW-1:0];
            c_d[k] = t[SW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
                c_q[k] <= c_d[k];
            end
        end
    end

    // Operand MSBs ride to the last stage so overflow is judged on the same beat as sum.
    assign sum  = s_q[LAST];
    assign cout = c_q[LAST];
    assign ovf  = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                  (s_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: directed vectors with literal expectations plus a queue-based arithmetic model.
module tb_pipelined_adder_sub;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    logic        v16, r16, rdy16, ov16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        cin16;

    int checks   = 0;
    int failures = 0;

    typedef struct packed { logic [31:0] s; logic c; logic o; } res_t;
    res_t        model_q[$];
    logic [31:0] got[$];

    logic        held_vld = 1'b0;
    logic [31:0] held_sum;
    logic        held_cout, held_ovf;

    always #5 clk = ~clk;

    pipelined_adder_sub #(.WIDTH(32), .STAGES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_adder_sub #(.WIDTH(16), .STAGES(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(v16), .in_ready(rdy16),
        .a(a16), .b(b16), .cin(cin16), .sub(1'b0), .out_valid(ov16),
        .out_ready(r16), .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: a +/- b +/- cin with wide signed/unsigned math.
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        res_t        r;
        logic [32:0] u;
        longint      sv;
        if (!sb) begin
            u  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            sv = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
            r.c = u[32];
        end else begin
            u  = {1'b0, x} - {1'b0, y} - {32'd0, ci};
            sv = longint'($signed(x)) - longint'($signed(y)) - longint'(ci);
            r.c = ~u[32];
        end
        r.s = u[31:0];
        r.o = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        return r;
    endfunction

    // Compare process: every delivered beat is checked against the model; stalled outputs must hold.
    always @(negedge clk) begin
        if (rst_n) begin
            res_t e;
            if (held_vld) begin
                chk("stall_valid_hold", out_valid, 1);
                chk("stall_data_hold", {sum, cout, ovf}, {held_sum, held_cout, held_ovf});
            end
            held_vld  = out_valid && !out_ready;
            held_sum  = sum;
            held_cout = cout;
            held_ovf  = ovf;
            if (out_valid && out_ready) begin
                if (model_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    e = model_q.pop_front();
                    chk("model_result", {sum, cout, ovf}, {e.s, e.c, e.o});
                end
                got.push_back(sum);
            end
            if (in_valid && in_ready) model_q.push_back(model(a, b, cin, sub));
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            in_valid = 0;
        end
    endtask

    task automatic single(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic sb, input logic [31:0] es,
                          input logic ec, input logic eo);
        int lat;
        @(posedge clk); #1;
        in_valid = 1; a = x; b = y; cin = ci; sub = sb; out_ready = 1;
        @(posedge clk); #1;
        in_valid = 0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, 4);
        chk({name, "_sum"}, sum, es);
        chk({name, "_cout"}, cout, ec);
        chk({name, "_ovf"}, ovf, eo);
    endtask

    initial begin
        logic ivs[16];
        logic ovs[16];
        int   i, cyc;
        logic [16:0] e17;

        rst_n = 0; in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; out_ready = 1;
        v16 = 0; r16 = 1; a16 = 0; b16 = 0; cin16 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {sum, cout, ovf}, 0);
        @(negedge clk); rst_n = 1;

        single("add_basic", 32'h5, 32'h3, 0, 0, 32'h8, 0, 0);
        single("add_ripple", 32'hFFFF_FFFF, 32'h0, 1, 0, 32'h0, 1, 0);
        single("add_ovf", 32'h7FFF_FFFF, 32'h1, 0, 0, 32'h8000_0000, 0, 1);
        single("sub_basic", 32'd10, 32'd3, 0, 1, 32'd7, 1, 0);
        single("sub_borrow", 32'd3, 32'd10, 0, 1, 32'hFFFF_FFF9, 0, 0);
        single("sub_ovf", 32'h8000_0000, 32'h1, 0, 1, 32'h7FFF_FFFF, 1, 1);
        single("sub_bin", 32'd10, 32'd3, 1, 1, 32'd6, 1, 0);
        idle(6);

        // Back-to-back stream with a four-cycle consumer stall.
        got.delete();
        i = 0; cyc = 0;
        while (got.size() < 8 && cyc < 60) begin
            @(posedge clk); #1;
            in_valid  = (i < 8);
            a = 32'(i); b = 32'd100; cin = 0; sub = 0;
            out_ready = !(cyc >= 6 && cyc <= 9);
            @(negedge clk);
            if (cyc >= 6 && cyc <= 9) chk("bp_in_ready_low", in_ready, 0);
            if (in_valid && in_ready) i++;
            cyc++;
        end
        out_ready = 1;
        idle(6);
        chk("bp_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("bp_order", got[k], 100 + k);

        // Alternating bubbles: valid pattern must reappear four cycles later.
        for (int t = 0; t < 16; t++) begin
            @(posedge clk); #1;
            in_valid = (t < 8) && (t % 2 == 0);
            a = 32'(t); b = 32'(t * 3); cin = t[0]; sub = t[1];
            ivs[t] = in_valid;
            @(negedge clk);
            ovs[t] = out_valid;
        end
        for (int t = 4; t < 16; t++) chk("bubble_pattern", ovs[t], ivs[t-4]);

        // Mid-flight reset discards everything in the pipe.
        @(posedge clk); #1;
        in_valid = 1; a = 1; b = 0; cin = 0; sub = 0;
        @(posedge clk); #1; a = 2;
        @(posedge clk); #1; a = 3;
        @(posedge clk); #1; in_valid = 0;
        @(posedge clk); #1;
        chk("mr_first_visible", out_valid, 1);
        #1 rst_n = 0;
        #1 chk("mr_async_clear", out_valid, 0);
        model_q.delete();
        #1 rst_n = 1;
        cyc = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) cyc++;
        end
        chk("mr_no_output", cyc, 0);
        single("mr_next", 32'h1234_0000, 32'h0000_5678, 1, 0, 32'h1234_5679, 0, 0);
        idle(6);
        chk("model_drained", model_q.size(), 0);

        // Single-stage 16-bit instance: registered adder with latency 1.
        @(posedge clk); #1;
        v16 = 1; a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1;
        for (int n = 0; n < 40; n++) begin
            e17 = {1'b0, a16} + {1'b0, b16} + {16'd0, cin16};
            @(posedge clk); #1;
            chk("w16_valid", ov16, 1);
            chk("w16_sum", {cout16, sum16}, e17);
            chk("w16_ovf", ovf16, (a16[15] == b16[15]) && (e17[15] != a16[15]));
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(0, 1));
        end
        v16 = 0;
        @(posedge clk); #1;
        chk("w16_drain", ov16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
